// File: rtl/cache_pkg.sv
// Shared constants and state encoding for the cache line fetch engine.
package cache_pkg;

    localparam int TAG_W   = 19;
    localparam int IDX_W   = 9;
    localparam int LINE_W  = 128;
    localparam int LADDR_W = TAG_W + IDX_W;
    localparam int MADDR_W = 32;
    localparam int TIMEOUT = 64;
    localparam int TMR_W   = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WB      = 3'd1,
        RD_REQ  = 3'd2,
        RD_WAIT = 3'd3,
        FILL    = 3'd4
    } state_t;

    // Byte address of the first byte of a 16-byte line.
    function automatic logic [MADDR_W-1:0] line_to_byte(input logic [LADDR_W-1:0] line_addr);
        return {line_addr, 4'h0};
    endfunction

endpackage

// File: rtl/mem_timeout_timer.sv
// Cycle counter that watches the wait for read data.
// The count saturates at TIMEOUT, and expired stays high until the counter is cleared.
module mem_timeout_timer
    import cache_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TMR_W-1:0] count;

    // Clear has priority over counting. The count stops once it reaches TIMEOUT.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != TMR_W'(TIMEOUT))) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == TMR_W'(TIMEOUT));

endmodule

// File: rtl/cache_line_fetch_engine.sv
// Memory-side miss handler. It writes back a dirty victim line, reads the missing line,
// and fills the line into cache_mem as valid and clean.
// Handshake: mem_wren and mem_rd are decoded from the state. Each one stays high and stable
// until the cycle in which mem_ready is high, and that cycle is the accept cycle.
// The two requests are never high together.
module cache_line_fetch_engine
    import cache_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         miss_req,
    input  logic [27:0]  miss_addr,
    input  logic         victim_valid,
    input  logic         victim_dirty,
    input  logic [18:0]  victim_tag,
    input  logic [127:0] victim_data,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic         fill_wren,
    output logic         fill_mark_dirty,
    output logic [27:0]  fill_addr,
    output logic [127:0] fill_data,
    output logic [31:0]  mem_addr,
    output logic [127:0] mem_wdata,
    output logic         mem_wren,
    output logic         mem_rd,
    input  logic         mem_ready,
    input  logic [127:0] mem_rdata,
    input  logic         mem_rdata_valid
);

    state_t state;
    state_t next_state;

    logic [LADDR_W-1:0] addr_q;
    logic [TAG_W-1:0]   vtag_q;
    logic [LINE_W-1:0]  vdata_q;

    logic rd_accept;
    logic tmr_clear;
    logic tmr_enable;
    logic tmr_expired;

    // The timer holds the number of cycles since the read was accepted.
    // It counts on the accept edge, so in the k-th cycle after the accept it holds k.
    assign rd_accept  = (state == RD_REQ) && mem_ready;
    assign tmr_enable = (state == RD_WAIT) || rd_accept;
    assign tmr_clear  = !tmr_enable;

    mem_timeout_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmr_clear),
        .enable  (tmr_enable),
        .expired (tmr_expired)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. If read data arrives in the timeout cycle, the data wins.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (miss_req) begin
                    next_state = (victim_valid && victim_dirty) ? WB : RD_REQ;
                end
            end
            WB: begin
                if (mem_ready) next_state = RD_REQ;
            end
            RD_REQ: begin
                if (mem_ready) next_state = RD_WAIT;
            end
            RD_WAIT: begin
                if (mem_rdata_valid) begin
                    next_state = FILL;
                end else if (tmr_expired) begin
                    next_state = IDLE;
                end
            end
            FILL: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Memory request decode. These outputs depend only on the state and the latched request.
    always_comb begin
        mem_wren  = 1'b0;
        mem_rd    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            WB: begin
                mem_wren  = 1'b1;
                mem_addr  = {vtag_q, addr_q[IDX_W-1:0], 4'h0};
                mem_wdata = vdata_q;
            end
            RD_REQ: begin
                mem_rd   = 1'b1;
                mem_addr = line_to_byte(addr_q);
            end
            default: begin
            end
        endcase
    end

    // Capture the miss address and the victim when a miss is accepted in IDLE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_q  <= '0;
            vtag_q  <= '0;
            vdata_q <= '0;
        end else if ((state == IDLE) && miss_req) begin
            addr_q  <= miss_addr;
            vtag_q  <= victim_tag;
            vdata_q <= victim_data;
        end
    end

    // Registered status and fill outputs, computed from the upcoming state.
    // The returned line is captured straight into fill_data on the edge that enters FILL.
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            fill_wren <= 1'b0;
            fill_addr <= '0;
            fill_data <= '0;
        end else begin
            busy      <= (next_state != IDLE);
            done      <= (next_state == FILL);
            fill_wren <= (next_state == FILL);
            err       <= (state == RD_WAIT) && (next_state == IDLE);
            fill_addr <= (next_state == FILL) ? addr_q : '0;
            fill_data <= (next_state == FILL) ? mem_rdata : '0;
        end
    end

    assign fill_mark_dirty = 1'b0;

endmodule

// File: tb/tb_cache_line_fetch_engine.sv
// Randomized bench for cache_line_fetch_engine. It checks every cycle against a timeline
// built from the miss parameters.
module tb_cache_line_fetch_engine;
    import cache_pkg::*;

    localparam int CAS_LATENCY = 5;
    localparam int RD_LAT      = CAS_LATENCY - 1;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         miss_req = 1'b0;
    logic [27:0]  miss_addr = '0;
    logic         victim_valid = 1'b0;
    logic         victim_dirty = 1'b0;
    logic [18:0]  victim_tag = '0;
    logic [127:0] victim_data = '0;
    logic         busy, done, err, fill_wren, fill_mark_dirty;
    logic [27:0]  fill_addr;
    logic [127:0] fill_data;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_wren, mem_rd;
    logic         mem_ready = 1'b0;
    logic [127:0] mem_rdata = '0;
    logic         mem_rdata_valid = 1'b0;

    int checks = 0;
    int failures = 0;
    logic [127:0] exp_q[$];

    cache_line_fetch_engine dut (
        .clk             (clk),
        .reset           (reset),
        .miss_req        (miss_req),
        .miss_addr       (miss_addr),
        .victim_valid    (victim_valid),
        .victim_dirty    (victim_dirty),
        .victim_tag      (victim_tag),
        .victim_data     (victim_data),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .fill_wren       (fill_wren),
        .fill_mark_dirty (fill_mark_dirty),
        .fill_addr       (fill_addr),
        .fill_data       (fill_data),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_wren        (mem_wren),
        .mem_rd          (mem_rd),
        .mem_ready       (mem_ready),
        .mem_rdata       (mem_rdata),
        .mem_rdata_valid (mem_rdata_valid)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Apply random values to the inputs the engine must ignore.
    task automatic drive_noise();
        miss_addr       = 28'($urandom());
        victim_valid    = 1'($urandom_range(0, 1));
        victim_dirty    = 1'($urandom_range(0, 1));
        victim_tag      = 19'($urandom());
        victim_data     = rand128();
        mem_ready       = 1'($urandom_range(0, 1));
        mem_rdata       = rand128();
        mem_rdata_valid = 1'($urandom_range(0, 1));
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_done"}, done, 0);
        check_val({tag, "_err"}, err, 0);
        check_val({tag, "_fill_wren"}, fill_wren, 0);
        check_val({tag, "_fill_dirty"}, fill_mark_dirty, 0);
        check_val({tag, "_fill_addr"}, fill_addr, 0);
        check_val({tag, "_fill_data"}, fill_data, 0);
        check_val({tag, "_mem_addr"}, mem_addr, 0);
        check_val({tag, "_mem_wdata"}, mem_wdata, 0);
        check_val({tag, "_mem_wren"}, mem_wren, 0);
        check_val({tag, "_mem_rd"}, mem_rd, 0);
    endtask

    // Idle cycles with miss_req low. No activity is expected.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            drive_noise();
            miss_req = 1'b0;
            @(negedge clk);
            check_val("idle_busy", busy, 0);
            check_val("idle_done", done, 0);
            check_val("idle_err", err, 0);
            check_val("idle_fill_wren", fill_wren, 0);
            check_val("idle_mem_rd", mem_rd, 0);
            check_val("idle_mem_wren", mem_wren, 0);
            @(posedge clk);
            #1;
        end
    endtask

    // One miss. Cycle t=0 is the IDLE cycle in which miss_req is sampled.
    // Writeback runs over cycles 1..1+wb_stall. The read is requested over cycles r0..a,
    // where a is the accept cycle. Data arrives at a+lat and done follows one cycle later.
    // On a timeout, err shows at a+TIMEOUT+1.
    task automatic run_miss(input logic [27:0] addr, input logic vv, input logic vd,
                            input logic [18:0] vtag, input logic [127:0] vdata,
                            input int wb_stall, input int rd_stall, input int lat,
                            input bit time_out);
        bit wb;
        int r0, a, last, wait_end;
        logic [127:0] rdata;
        bit exp_busy, exp_wren, exp_rd, exp_done, exp_err;
        wb       = vv && vd;
        r0       = wb ? 2 + wb_stall : 1;
        a        = r0 + rd_stall;
        last     = time_out ? a + TIMEOUT + 1 : a + lat + 1;
        wait_end = time_out ? a + TIMEOUT : a + lat;
        rdata    = rand128();
        for (int t = 0; t <= last; t++) begin
            drive_noise();
            if (t == 0) begin
                miss_req     = 1'b1;
                miss_addr    = addr;
                victim_valid = vv;
                victim_dirty = vd;
                victim_tag   = vtag;
                victim_data  = vdata;
            end else if (t == last && time_out) begin
                miss_req = 1'b0;
            end else begin
                miss_req = 1'($urandom_range(0, 1));
            end
            if (wb && t >= 1 && t <= 1 + wb_stall) mem_ready = (t == 1 + wb_stall);
            if (t >= r0 && t <= a) mem_ready = (t == a);
            if (t >= a + 1 && t <= wait_end) begin
                mem_rdata_valid = !time_out && (t == a + lat);
                if (mem_rdata_valid) begin
                    mem_rdata = rdata;
                    exp_q.push_back(rdata);
                end
            end
            @(negedge clk);
            exp_busy = (t >= 1) && (t <= (time_out ? a + TIMEOUT : last));
            exp_wren = wb && (t >= 1) && (t <= 1 + wb_stall);
            exp_rd   = (t >= r0) && (t <= a);
            exp_done = !time_out && (t == last);
            exp_err  = time_out && (t == last);
            check_val("busy", busy, exp_busy);
            check_val("mem_wren", mem_wren, exp_wren);
            check_val("mem_rd", mem_rd, exp_rd);
            check_val("done", done, exp_done);
            check_val("fill_wren", fill_wren, exp_done);
            check_val("err", err, exp_err);
            check_val("fill_mark_dirty", fill_mark_dirty, 0);
            if (exp_wren) begin
                check_val("wb_addr", mem_addr, {vtag, addr[8:0], 4'h0});
                check_val("wb_data", mem_wdata, vdata);
            end
            if (exp_rd) check_val("rd_addr", mem_addr, {addr, 4'h0});
            if (exp_done) begin
                check_val("fill_addr", fill_addr, addr);
                check_val("exp_q_level", exp_q.size(), 1);
                if (exp_q.size() > 0) check_val("fill_data", fill_data, exp_q.pop_front());
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Pulse reset while the engine waits for read data, then send late data that must be ignored.
    task automatic reset_in_wait();
        for (int t = 0; t <= 7; t++) begin
            drive_noise();
            miss_req = (t == 0);
            if (t == 0) begin
                miss_addr    = 28'h0ABCDEF;
                victim_valid = 1'b0;
            end
            if (t == 1) mem_ready = 1'b1;
            if (t == 2 || t == 3) mem_rdata_valid = 1'b0;
            if (t >= 4) mem_rdata_valid = 1'b1;
            reset = (t == 3) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (t == 2) check_val("rst_pre_busy", busy, 1);
            if (t == 4) check_all_zero("rst_mid");
            if (t > 4) begin
                check_val("rst_late_fill_wren", fill_wren, 0);
                check_val("rst_late_busy", busy, 0);
                check_val("rst_late_done", done, 0);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int lat;
        bit to;
        // Reset
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle_cycles(2);

        // Clean miss
        run_miss(28'h0000123, 1'b0, 1'b0, 19'h0, 128'h0, 0, 0, RD_LAT, 1'b0);
        // Dirty miss
        run_miss({19'h12345, 9'h023}, 1'b1, 1'b1, 19'h7FFFF, {16{8'hA5}}, 0, 0, RD_LAT, 1'b0);
        // Valid but clean victim takes the short path
        run_miss(28'h5555AAA, 1'b1, 1'b0, 19'h1, rand128(), 0, 0, RD_LAT, 1'b0);
        // Back-pressure on the read request
        run_miss(28'h0000456, 1'b0, 1'b0, 19'h0, 128'h0, 0, 3, RD_LAT, 1'b0);
        // Back-pressure on the writeback
        run_miss(28'h1234567, 1'b1, 1'b1, 19'h2AAAA, rand128(), 2, 1, RD_LAT, 1'b0);
        idle_cycles(1);
        // Timeout
        run_miss(28'h0000789, 1'b0, 1'b0, 19'h0, 128'h0, 0, 0, 0, 1'b1);
        // Data in the timeout cycle wins
        run_miss(28'h0FEDCBA, 1'b1, 1'b1, 19'h3C3C3, rand128(), 0, 0, TIMEOUT, 1'b0);
        // Reset during the read wait
        reset_in_wait();
        idle_cycles(1);

        // Random misses, some back to back
        for (int n = 0; n < 40; n++) begin
            to  = ($urandom_range(0, 9) == 0);
            lat = ($urandom_range(0, 7) == 0) ? $urandom_range(1, TIMEOUT) : $urandom_range(1, 8);
            run_miss(28'($urandom()), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     19'($urandom()), rand128(), $urandom_range(0, 3), $urandom_range(0, 3),
                     lat, to);
            if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 2));
        end

        check_val("exp_q_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
